matriz_led_varredura: RTL and testbench
=======================================

Name: matriz_led_varredura

Overview:
- Scan sequencer that drives the 5-column x 7-row LED matrix from a 35-bit frame.
- Produces the 4-bit scan code consumed by the column decoder, plus one-hot column enables and the 7 row bits for the active column.
- Double-buffers the selected frame (map or attack), so a frame update never tears mid-scan.
- Sits between the game logic producing codigoMap/codigoAtk and the physical matrix pins.

Parameters:
- ON_CYC, 16, clock cycles a column is driven (>=1).
- BLANK_CYC, 2, dead-time cycles with all rows off before each column (0 = no blanking).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- ch6  input  1  frame select: 0 = codigoMap, 1 = codigoAtk (sampled at LOAD only)
- ch7  input  1  display enable
- codigoMap  input  35  map frame; column c row r = bit 7*c+r
- codigoAtk  input  35  attack frame, same layout
- scan_code  output  4  column code for the column decoder: A=0, B=4, C=2, D=6, E=1; bit3 always 0
- col  output  5  one-hot column enable, bit0=A ... bit4=E
- row  output  7  row data for the active column, active-high
- frame_done  output  1  one-cycle pulse after column E finishes
- busy  output  1  high in any state except IDLE

Behaviour:
- One clock, synchronous active-high reset. All outputs are registered.
- Reset values:
  - scan_code=0, col=0, row=0, frame_done=0, busy=0
  - state=IDLE, column index=0, frame buffer=0
- States: IDLE, LOAD, BLANK, DRIVE.
- IDLE:
  - Outputs zero.
  - ch7=1 moves to LOAD on the next edge.
- LOAD (exactly 1 cycle):
  - frame buffer <= (ch6 ? codigoAtk : codigoMap); column index <= 0.
  - Next state is BLANK, or DRIVE if BLANK_CYC=0.
  - col=0 and row=0 during LOAD.
- BLANK (BLANK_CYC cycles):
  - scan_code = code of the current column; col=0; row=0.
  - Then DRIVE.
- DRIVE (ON_CYC cycles):
  - col = one-hot of the current index; row = buffer[7*idx +: 7]; scan_code = code of idx.
  - On the last cycle with idx<4: idx+1, go to BLANK (or DRIVE).
  - On the last cycle with idx==4: assert frame_done for the next cycle, then go to LOAD.
- Outputs change one cycle after the registered state change. No glitch cycle may have two col bits set.
- Frame period = 1 + 5*(BLANK_CYC+ON_CYC) cycles (91 at defaults).
- Input sampling:
  - codigoMap, codigoAtk and ch6 changes mid-frame are ignored until the next LOAD.
  - ch6 toggling mid-frame never switches the buffer.
- ch7 falling in any state:
  - Next edge: state=IDLE, all outputs 0, idx=0.
  - No frame_done, even if the drop occurs on column E's last cycle.
- ch7 rising again always restarts at LOAD, column A. There is no resume.
- Reset mid-scan overrides everything and returns to reset values on the next edge.
- Cycle counter width is sized for max(ON_CYC, BLANK_CYC). It wraps to 0 at each phase change.

Test Plan:
- Reset with ch7=1 held, then release reset → LOAD 1 cycle later. scan_code sequence 0,4,2,6,1 with each code held 18 cycles. frame_done pulses once at cycle 91, then the next LOAD.
- codigoMap=35'h0000000_7F (column A all on), ch6=0 → row=7'h7F only while col=5'b00001 and not blanking. row=0 for columns B–E and during all BLANK cycles.
- ch6=1, codigoAtk=1<<34 (E row 6), codigoMap all-ones → only col=5'b10000 with row=7'h40 is seen. Flipping ch6 to 0 mid-frame has no effect until after frame_done.
- Change codigoMap while column C is driving → C and D still show the old data. The new data appears only after the next LOAD.
- Drop ch7 on the last DRIVE cycle of column E → frame_done stays 0, outputs go 0 next cycle, busy=0. Raising ch7 again restarts at scan_code=0.
- Override BLANK_CYC=0, ON_CYC=1 → column codes advance every cycle, period 6 cycles, and col never shows two bits set. Asserting reset mid-frame → all outputs 0 on the next edge.

Source files
------------

// File: rtl/matriz_led_varredura.sv
// Purpose : scans a 5-column x 7-row LED matrix from a double-buffered 35-bit frame.
// Latency : every output is registered and follows the FSM state by one cycle.
//           One frame takes 1 + 5*(BLANK_CYC+ON_CYC) cycles.
// Backpressure: none. ch7 low stops the scan on the next edge; ch7 high restarts at column A.
//
// Ports:
//   clk, reset           clock and synchronous active-high reset
//   ch6                  frame select (0 = codigoMap, 1 = codigoAtk), sampled only in LOAD
//   ch7                  display enable
//   codigoMap/codigoAtk  35-bit frames; column c, row r is bit 7*c+r
//   scan_code            decoder code of the active column (A=0,B=4,C=2,D=6,E=1)
//   col, row             one-hot column enable and active-high row data
//   frame_done, busy     end-of-frame pulse and not-idle flag
module matriz_led_varredura #(
    parameter int ON_CYC    = 16,
    parameter int BLANK_CYC = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ch6,
    input  logic        ch7,
    input  logic [34:0] codigoMap,
    input  logic [34:0] codigoAtk,
    output logic [3:0]  scan_code,
    output logic [4:0]  col,
    output logic [6:0]  row,
    output logic        frame_done,
    output logic        busy
);

    localparam int MAX_CYC = (ON_CYC > BLANK_CYC) ? ON_CYC : BLANK_CYC;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYC - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

    typedef enum logic [1:0] {IDLE, LOAD, BLANK, DRIVE} state_t;

    state_t        state;
    logic [2:0]    idx;
    logic [CW-1:0] cnt;
    logic [34:0]   frame_buf;

    function automatic logic [3:0] code_of(input logic [2:0] i);
        case (i)
            3'd0:    code_of = 4'd0;
            3'd1:    code_of = 4'd4;
            3'd2:    code_of = 4'd2;
            3'd3:    code_of = 4'd6;
            default: code_of = 4'd1;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= 3'd0;
            cnt        <= '0;
            frame_buf  <= '0;
            scan_code  <= 4'd0;
            col        <= 5'd0;
            row        <= 7'd0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else if (!ch7) begin
            // Disable wins over everything, including the end-of-frame pulse.
            state      <= IDLE;
            idx        <= 3'd0;
            cnt        <= '0;
            scan_code  <= 4'd0;
            col        <= 5'd0;
            row        <= 7'd0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            busy       <= (state != IDLE);
            case (state)
                IDLE: begin
                    scan_code <= 4'd0;
                    col       <= 5'd0;
                    row       <= 7'd0;
                    state     <= LOAD;
                end
                LOAD: begin
                    // The only place the frame inputs are sampled, so a scan never tears.
                    frame_buf <= ch6 ? codigoAtk : codigoMap;
                    idx       <= 3'd0;
                    cnt       <= '0;
                    scan_code <= 4'd0;
                    col       <= 5'd0;
                    row       <= 7'd0;
                    state     <= (BLANK_CYC == 0) ? DRIVE : BLANK;
                end
                BLANK: begin
                    // The decoder code settles while all rows are dark.
                    scan_code <= code_of(idx);
                    col       <= 5'd0;
                    row       <= 7'd0;
                    if (cnt == BLANK_LAST) begin
                        cnt   <= '0;
                        state <= DRIVE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DRIVE: begin
                    scan_code <= code_of(idx);
                    col       <= 5'b00001 << idx;
                    row       <= frame_buf[7*32'(idx) +: 7];
                    if (cnt == ON_LAST) begin
                        cnt <= '0;
                        if (idx == 3'd4) begin
                            frame_done <= 1'b1;
                            state      <= LOAD;
                        end else begin
                            idx   <= idx + 3'd1;
                            state <= (BLANK_CYC == 0) ? DRIVE : BLANK;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matriz_led_varredura.sv
// Purpose : self-checking bench for matriz_led_varredura. It runs one instance at the default
//           timing and one with BLANK_CYC=0, ON_CYC=1.
// Latency : a position-in-frame model pushes the expected outputs at each posedge; the DUT is
//           sampled at the following negedge.
// Backpressure: not applicable.
module tb_matriz_led_varredura;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, ch6, ch7, reset2, ch7_2;
    logic [34:0] codigo_map, codigo_atk;

    logic [3:0] scan_code, scan_code2;
    logic [4:0] col, col2;
    logic [6:0] row, row2;
    logic       frame_done, frame_done2, busy, busy2;

    matriz_led_varredura #(.ON_CYC(16), .BLANK_CYC(2)) u_dut (
        .clk(clk), .reset(reset), .ch6(ch6), .ch7(ch7),
        .codigoMap(codigo_map), .codigoAtk(codigo_atk),
        .scan_code(scan_code), .col(col), .row(row),
        .frame_done(frame_done), .busy(busy)
    );

    matriz_led_varredura #(.ON_CYC(1), .BLANK_CYC(0)) u_fast (
        .clk(clk), .reset(reset2), .ch6(ch6), .ch7(ch7_2),
        .codigoMap(codigo_map), .codigoAtk(codigo_atk),
        .scan_code(scan_code2), .col(col2), .row(row2),
        .frame_done(frame_done2), .busy(busy2)
    );

    wire [17:0] v1 = {scan_code, col, row, frame_done, busy};
    wire [17:0] v2 = {scan_code2, col2, row2, frame_done2, busy2};

    localparam int B1 = 2, O1 = 16, P1 = 1 + 5 * (B1 + O1);
    localparam int B2 = 0, O2 = 1,  P2 = 1 + 5 * (B2 + O2);

    int checks = 0;
    int fails  = 0;

    logic [17:0] q1[$];
    logic [17:0] q2[$];
    logic [17:0] e1, e2;
    int          pos1 = -1, pos2 = -1;
    logic [34:0] buf1 = '0, buf2 = '0;

    // Expected outputs from the position of the state inside the frame (0 = LOAD).
    function automatic logic [17:0] model_out(input int pos, input logic [34:0] b,
                                              input int bl, input int on);
        int q, c, r;
        logic [3:0] sc;
        logic [4:0] cl;
        logic [6:0] rw;
        logic       fd;
        if (pos == 0) return {4'd0, 5'd0, 7'd0, 1'b0, 1'b1};
        q = pos - 1;
        c = q / (bl + on);
        r = q % (bl + on);
        case (c)
            0:       sc = 4'd0;
            1:       sc = 4'd4;
            2:       sc = 4'd2;
            3:       sc = 4'd6;
            default: sc = 4'd1;
        endcase
        if (r < bl) begin
            cl = 5'd0;
            rw = 7'd0;
        end else begin
            cl = 5'd1 << c;
            rw = b[7*c +: 7];
        end
        fd = (pos == 5 * (bl + on));
        return {sc, cl, rw, fd, 1'b1};
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            q1.push_back(18'd0); pos1 = -1; buf1 = '0;
        end else if (!ch7) begin
            q1.push_back(18'd0); pos1 = -1;
        end else if (pos1 < 0) begin
            q1.push_back(18'd0); pos1 = 0;
        end else begin
            q1.push_back(model_out(pos1, buf1, B1, O1));
            if (pos1 == 0) buf1 = ch6 ? codigo_atk : codigo_map;
            pos1 = (pos1 + 1) % P1;
        end
        if (reset2) begin
            q2.push_back(18'd0); pos2 = -1; buf2 = '0;
        end else if (!ch7_2) begin
            q2.push_back(18'd0); pos2 = -1;
        end else if (pos2 < 0) begin
            q2.push_back(18'd0); pos2 = 0;
        end else begin
            q2.push_back(model_out(pos2, buf2, B2, O2));
            if (pos2 == 0) buf2 = ch6 ? codigo_atk : codigo_map;
            pos2 = (pos2 + 1) % P2;
        end
    end

    // Advance to the next negedge and pop the expectations for the edge just taken.
    task automatic tick();
        @(negedge clk);
        e1 = (q1.size() > 0) ? q1.pop_front() : 18'hx;
        e2 = (q2.size() > 0) ? q2.pop_front() : 18'hx;
    endtask

    task automatic restart1();
        reset = 1'b1;
        ch7   = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; ch7 = 1'b1; ch6 = 1'b0;
        reset2 = 1'b1; ch7_2 = 1'b0;
        codigo_map = 35'h7F; codigo_atk = '0;
        for (int t = 0; t < 3; t++) begin
            tick();
            checks++;
            if (v1 !== 18'd0) begin fails++; $display("FAIL reset_outputs t=%0d got=%h want=0", t, v1); end
            checks++;
            if (v2 !== 18'd0) begin fails++; $display("FAIL reset_outputs_fast t=%0d got=%h want=0", t, v2); end
        end
        reset = 1'b0;
        tick();
        checks++;
        if (v1 !== 18'd0) begin fails++; $display("FAIL idle_to_load got=%h want=0", v1); end
        tick();
        checks++;
        if (v1 !== {4'd0, 5'd0, 7'd0, 1'b0, 1'b1}) begin
            fails++; $display("FAIL load_busy got=%h want=%h", v1, {4'd0, 5'd0, 7'd0, 1'b0, 1'b1});
        end
    endtask

    task automatic test_scan_sequence();
        int fd_cnt, fd_first, lit, seg_len;
        logic [3:0] prev;
        codigo_map = 35'h7F; ch6 = 1'b0;
        restart1();
        fd_cnt = 0; fd_first = -1; lit = 0; seg_len = 0; prev = 4'd0;
        for (int t = 1; t <= 2 * P1 + 3; t++) begin
            tick();
            checks++;
            if (v1 !== e1) begin fails++; $display("FAIL scan_model t=%0d got=%h want=%h", t, v1, e1); end
            if (frame_done) begin
                fd_cnt++;
                if (fd_first < 0) fd_first = t;
            end
            if (row !== 7'd0) begin
                lit++;
                checks++;
                if (col !== 5'b00001 || row !== 7'h7F) begin
                    fails++; $display("FAIL scan_row_only_a t=%0d col=%b row=%h want col=00001 row=7f", t, col, row);
                end
            end
            if (scan_code !== prev) begin
                if (prev != 4'd0) begin
                    checks++;
                    if (seg_len != 18) begin fails++; $display("FAIL scan_hold code=%0d held=%0d want=18", prev, seg_len); end
                end
                seg_len = 0;
                prev = scan_code;
            end
            seg_len++;
        end
        checks++;
        if (fd_cnt != 2) begin fails++; $display("FAIL scan_fd_count got=%0d want=2", fd_cnt); end
        checks++;
        if (fd_first != P1 + 1) begin fails++; $display("FAIL scan_fd_cycle got=%0d want=%0d", fd_first, P1 + 1); end
        checks++;
        if (lit != 2 * O1) begin fails++; $display("FAIL scan_lit_cycles got=%0d want=%0d", lit, 2 * O1); end
    endtask

    task automatic test_atk_select();
        int hits_e, hits_a;
        codigo_map = '1; codigo_atk = 35'h1 << 34; ch6 = 1'b1;
        restart1();
        hits_e = 0; hits_a = 0;
        for (int t = 1; t <= 2 * P1; t++) begin
            if (t == 40) ch6 = 1'b0;
            tick();
            checks++;
            if (v1 !== e1) begin fails++; $display("FAIL atk_model t=%0d got=%h want=%h", t, v1, e1); end
            if (t <= P1 + 1 && row !== 7'd0) begin
                hits_e++;
                checks++;
                if (col !== 5'b10000 || row !== 7'h40) begin
                    fails++; $display("FAIL atk_only_e t=%0d col=%b row=%h want col=10000 row=40", t, col, row);
                end
            end
            if (t > P1 + 1 && col == 5'b00001 && row == 7'h7F) hits_a++;
        end
        checks++;
        if (hits_e != O1) begin fails++; $display("FAIL atk_e_cycles got=%0d want=%0d", hits_e, O1); end
        checks++;
        if (hits_a != O1) begin fails++; $display("FAIL atk_map_after_load got=%0d want=%0d", hits_a, O1); end
    endtask

    task automatic test_midframe_update();
        logic [34:0] old_map, new_map;
        logic        changed;
        int          old_hits, new_hits;
        old_map = 35'h2_AAAA_AAAA; new_map = 35'h1_2345_6789;
        codigo_map = old_map; ch6 = 1'b0;
        restart1();
        changed = 1'b0; old_hits = 0; new_hits = 0;
        for (int t = 1; t <= P1 + 60; t++) begin
            tick();
            checks++;
            if (v1 !== e1) begin fails++; $display("FAIL upd_model t=%0d got=%h want=%h", t, v1, e1); end
            if (t <= P1 + 1 && (col == 5'b00100 || col == 5'b01000)) begin
                old_hits++;
                checks++;
                if (row !== ((col == 5'b00100) ? old_map[14 +: 7] : old_map[21 +: 7])) begin
                    fails++; $display("FAIL upd_old_data t=%0d col=%b row=%h", t, col, row);
                end
            end
            if (t > P1 + 1 && col == 5'b00100 && row == new_map[14 +: 7]) new_hits++;
            if (!changed && col == 5'b00100) begin
                codigo_map = new_map;
                changed = 1'b1;
            end
        end
        checks++;
        if (old_hits != 2 * O1) begin fails++; $display("FAIL upd_old_cycles got=%0d want=%0d", old_hits, 2 * O1); end
        checks++;
        if (new_hits != O1) begin fails++; $display("FAIL upd_new_cycles got=%0d want=%0d", new_hits, O1); end
    endtask

    task automatic test_ch7_drop();
        codigo_map = 35'h7F; ch6 = 1'b0;
        restart1();
        for (int t = 1; t <= P1; t++) begin
            tick();
            checks++;
            if (v1 !== e1) begin fails++; $display("FAIL drop_model t=%0d got=%h want=%h", t, v1, e1); end
        end
        // Now in the last DRIVE cycle of column E.
        ch7 = 1'b0;
        for (int t = 0; t < 3; t++) begin
            tick();
            checks++;
            if (v1 !== 18'd0) begin fails++; $display("FAIL drop_zero t=%0d got=%h want=0", t, v1); end
        end
        ch7 = 1'b1;
        for (int t = 1; t <= 21; t++) begin
            tick();
            checks++;
            if (v1 !== e1) begin fails++; $display("FAIL drop_restart_model t=%0d got=%h want=%h", t, v1, e1); end
            checks++;
            if (scan_code !== ((t <= 20) ? 4'd0 : 4'd4)) begin
                fails++; $display("FAIL drop_restart_code t=%0d got=%0d want=%0d", t, scan_code, (t <= 20) ? 0 : 4);
            end
        end
    endtask

    task automatic test_fast_params();
        int fd_cnt, last_fd;
        codigo_map = 35'h7_FFFF_FFFF; ch6 = 1'b0;
        reset2 = 1'b1; ch7_2 = 1'b1;
        tick();
        tick();
        reset2 = 1'b0;
        fd_cnt = 0; last_fd = -1;
        for (int t = 1; t <= 30; t++) begin
            tick();
            checks++;
            if (v2 !== e2) begin fails++; $display("FAIL fast_model t=%0d got=%h want=%h", t, v2, e2); end
            checks++;
            if ($countones(col2) > 1) begin fails++; $display("FAIL fast_onehot t=%0d col=%b want at most 1 bit", t, col2); end
            if (frame_done2) begin
                fd_cnt++;
                if (last_fd >= 0) begin
                    checks++;
                    if (t - last_fd != P2) begin fails++; $display("FAIL fast_period got=%0d want=%0d", t - last_fd, P2); end
                end
                last_fd = t;
            end
        end
        checks++;
        if (fd_cnt != 4) begin fails++; $display("FAIL fast_fd_count got=%0d want=4", fd_cnt); end
        reset2 = 1'b1;
        tick();
        checks++;
        if (v2 !== 18'd0) begin fails++; $display("FAIL fast_reset_midframe got=%h want=0", v2); end
        reset2 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scan_sequence();
        test_atk_select();
        test_midframe_update();
        test_ch7_drop();
        test_fast_params();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
